// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes encoder A/B, validates Gray-code quarter-steps and
// drives a wrapping up/down position counter with step/err pulses.
module quad_decoder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  logic [1:0]       prev_q, prev_d;
  logic [1:0]       warm_q, warm_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  logic             primed;

  assign primed = (warm_q == 2'd3);

  always_comb begin
    s1_d    = {a, b};
    s2_d    = s1_q;
    prev_d  = s2_q;
    warm_d  = primed ? warm_q : warm_q + 2'd1;
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    // {prev, cur}: A-leading order 00->10->11->01 counts up, the reverse counts down.
    if (primed && (s2_q != prev_q)) begin
      unique case ({prev_q, s2_q})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
          count_d = count_q + 1'b1;
          dir_d   = 1'b1;
          step_d  = 1'b1;
        end
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
          count_d = count_q - 1'b1;
          dir_d   = 1'b0;
          step_d  = 1'b1;
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 2'b00;
      s2_q    <= 2'b00;
      prev_q  <= 2'b00;
      warm_q  <= 2'd0;
      count_q <= '0;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      warm_q  <= warm_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule
